spi_sample_receiver: RTL and testbench

- SPI target-side receiver for the DAC frame format the sample output path transmits: 24-bit frames, 8-bit channel command then 16-bit code, MSB first, CS active-low.
- Decodes channel A/B frames, undoes the scaling and offset, and presents a left/right 32-bit sample pair with a one-cycle valid strobe.
- Used as a loopback checker on board and as a receive path for externally generated sample streams.

---
 rtl/spi_sample_receiver.sv | 217 +++++++++++++++++++++
 tb/tb_spi_sample_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sample_receiver.sv
// spi_sample_receiver: SPI target receiver for 24-bit DAC frames (8-bit command, 16-bit code).
// A channel-A frame holds a left sample; the next channel-B frame presents the L/R pair.
// Optional build macro SPI_RX_TIMEOUT_EN bounds how long CS may stay low in a frame.
module spi_sample_receiver #(
    parameter logic [31:0] SAMPLE_OFFSET  = 32'h0002_1000,
    parameter logic [7:0]  RECV_CHANNEL_A = 8'b0011_0001,
    parameter logic [7:0]  RECV_CHANNEL_B = 8'b0011_0010,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2048
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_SPI_CS,
    input  logic        i_SPI_Clock,
    input  logic        i_SPI_Data,
    output logic [31:0] o_Sample_L,
    output logic [31:0] o_Sample_R,
    output logic        o_Sample_Valid,
    output logic        o_Frame_Error,
    output logic        o_Busy
);

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned SAMPLE_W   = 32;
    localparam int unsigned CODE_W     = 16;
    localparam int unsigned CMD_W      = 8;
    localparam int unsigned TMO_W      = 16;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        sm_idle   = 2'd0,
        sm_shift  = 2'd1,
        sm_decode = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Synchroniser stages and edge history
    logic cs_meta, cs_sync, cs_prev;
    logic sck_meta, sck_sync, sck_prev;
    logic dat_meta, dat_sync;
    logic cs_armed_q;

    logic cs_rise_c, cs_fall_c, sck_rise_c;

    // Datapath registers and their next values
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  pending_q, pending_d;
    logic [SAMPLE_W-1:0]   held_l_q, held_l_d;
    logic [SAMPLE_W-1:0]   sample_l_d, sample_r_d;
    logic                  valid_d, error_d, busy_d;

    logic [CMD_W-1:0]      cmd_c;
    logic [CODE_W-1:0]     code_c;
    logic [SAMPLE_W-1:0]   recon_c;

`ifdef SPI_RX_TIMEOUT_EN
    logic [TMO_W-1:0] timeout_q, timeout_d;
`else
    // Timeout parameter has no function in this build
    logic [TMO_W-1:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    // Undo the DAC scaling (x4) and offset; wraps modulo 2^32
    function automatic logic [SAMPLE_W-1:0] reconstruct(input logic [CODE_W-1:0] code);
        return {14'h0000, code, 2'b00} - SAMPLE_OFFSET;
    endfunction

    assign cmd_c      = shift_q[FRAME_BITS-1 -: CMD_W];
    assign code_c     = shift_q[CODE_W-1:0];
    assign recon_c    = reconstruct(code_c);

    // Reset clears the history to 0, so a frame already under way never shows a CS falling edge
    assign cs_rise_c  = cs_sync & ~cs_prev;
    assign cs_fall_c  = ~cs_sync & cs_prev;
    assign sck_rise_c = sck_sync & ~sck_prev;

    // Two-flop synchronisers plus one stage of history for edge detection
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cs_meta    <= 1'b0;
            cs_sync    <= 1'b0;
            cs_prev    <= 1'b0;
            sck_meta   <= 1'b0;
            sck_sync   <= 1'b0;
            sck_prev   <= 1'b0;
            dat_meta   <= 1'b0;
            dat_sync   <= 1'b0;
            cs_armed_q <= 1'b0;
        end else begin
            cs_meta    <= i_SPI_CS;
            cs_sync    <= cs_meta;
            cs_prev    <= cs_sync;
            sck_meta   <= i_SPI_Clock;
            sck_sync   <= sck_meta;
            sck_prev   <= sck_sync;
            dat_meta   <= i_SPI_Data;
            dat_sync   <= dat_meta;
            if (cs_sync) begin
                cs_armed_q <= 1'b1;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q        <= sm_idle;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            pending_q      <= 1'b0;
            held_l_q       <= '0;
            o_Sample_L     <= '0;
            o_Sample_R     <= '0;
            o_Sample_Valid <= 1'b0;
            o_Frame_Error  <= 1'b0;
            o_Busy         <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
            timeout_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            pending_q      <= pending_d;
            held_l_q       <= held_l_d;
            o_Sample_L     <= sample_l_d;
            o_Sample_R     <= sample_r_d;
            o_Sample_Valid <= valid_d;
            o_Frame_Error  <= error_d;
            o_Busy         <= busy_d;
`ifdef SPI_RX_TIMEOUT_EN
            timeout_q      <= timeout_d;
`endif
        end
    end

    // Next-state, frame capture and decode
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        pending_d  = pending_q;
        held_l_d   = held_l_q;
        sample_l_d = o_Sample_L;
        sample_r_d = o_Sample_R;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        busy_d     = cs_armed_q & ~cs_sync;
`ifdef SPI_RX_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif

        unique case (state_q)
            sm_idle: begin
                if (cs_fall_c) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
`ifdef SPI_RX_TIMEOUT_EN
                    timeout_d = '0;
`endif
                    state_d   = sm_shift;
                end
            end

            sm_shift: begin
                // CS rising wins over a coincident SCK edge
                if (cs_rise_c) begin
                    state_d = sm_decode;
`ifdef SPI_RX_TIMEOUT_EN
                end else if (timeout_q == TIMEOUT_CYCLES) begin
                    // Back to idle; only a fresh CS falling edge can re-arm
                    error_d   = 1'b1;
                    pending_d = 1'b0;
                    state_d   = sm_idle;
`endif
                end else begin
`ifdef SPI_RX_TIMEOUT_EN
                    timeout_d = timeout_q + TMO_W'(1);
`endif
                    if (sck_rise_c && !cs_sync) begin
                        shift_d = {shift_q[FRAME_BITS-2:0], dat_sync};
                        if (bit_cnt_q != CNT_MAX) begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end

            sm_decode: begin
                state_d = sm_idle;
                if (bit_cnt_q != FRAME_LEN) begin
                    error_d = 1'b1;
                end else if (cmd_c == RECV_CHANNEL_A) begin
                    held_l_d  = recon_c;
                    pending_d = 1'b1;
                end else if (cmd_c == RECV_CHANNEL_B && pending_q) begin
                    sample_l_d = held_l_q;
                    sample_r_d = recon_c;
                    valid_d    = 1'b1;
                    pending_d  = 1'b0;
                end else begin
                    error_d = 1'b1;
                end
            end

            default: begin
                state_d = sm_idle;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_sample_receiver.sv
// tb_spi_sample_receiver: directed and random SPI frames against a frame-level reference model.
module tb_spi_sample_receiver;

    localparam logic [7:0]  CH_A   = 8'h31;
    localparam logic [7:0]  CH_B   = 8'h32;
    localparam logic [31:0] OFFSET = 32'h0002_1000;

    logic        i_Clock;
    logic        i_Reset;
    logic        i_SPI_CS;
    logic        i_SPI_Clock;
    logic        i_SPI_Data;
    logic [31:0] o_Sample_L;
    logic [31:0] o_Sample_R;
    logic        o_Sample_Valid;
    logic        o_Frame_Error;
    logic        o_Busy;

    int total = 0;
    int bad   = 0;
    int v_cnt = 0;
    int e_cnt = 0;

    // Reference model state
    logic        m_pending;
    logic [31:0] m_held;
    logic [31:0] m_l;
    logic [31:0] m_r;

    spi_sample_receiver dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .i_SPI_CS      (i_SPI_CS),
        .i_SPI_Clock   (i_SPI_Clock),
        .i_SPI_Data    (i_SPI_Data),
        .o_Sample_L    (o_Sample_L),
        .o_Sample_R    (o_Sample_R),
        .o_Sample_Valid(o_Sample_Valid),
        .o_Frame_Error (o_Frame_Error),
        .o_Busy        (o_Busy)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Strobe counters and mutual exclusion of valid/error
    always @(negedge i_Clock) begin
        if (o_Sample_Valid) v_cnt++;
        if (o_Frame_Error)  e_cnt++;
        if (o_Sample_Valid || o_Frame_Error)
            check("strobe_excl", 32'(o_Sample_Valid & o_Frame_Error), 32'h0);
    end

    function automatic logic [31:0] model_recon(input logic [15:0] code);
        return (32'(code) * 32'd4) - OFFSET;
    endfunction

    // Drive one frame, low nbits of word MSB first; SCK period is 8 system clocks
    task automatic send_frame(input logic [31:0] word, input int nbits,
                              output int lat, output logic mid_busy);
        i_SPI_CS = 1'b0;
        repeat (6) @(negedge i_Clock);
        mid_busy = o_Busy;
        for (int i = nbits - 1; i >= 0; i--) begin
            i_SPI_Data = word[i];
            repeat (4) @(negedge i_Clock);
            i_SPI_Clock = 1'b1;
            repeat (4) @(negedge i_Clock);
            i_SPI_Clock = 1'b0;
        end
        repeat (4) @(negedge i_Clock);
        i_SPI_CS = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_Clock);
            if ((o_Sample_Valid || o_Frame_Error) && lat == 0) lat = k;
        end
        repeat (4) @(negedge i_Clock);
    endtask

    // Predict the outcome of a frame, send it and compare
    task automatic do_frame(input logic [31:0] word, input int nbits, input string tag);
        int          e0, v0, lat, exp_e, exp_v;
        logic        mid_busy;
        logic [7:0]  cmd;
        logic [15:0] code;
        cmd   = word[23:16];
        code  = word[15:0];
        exp_e = 0;
        exp_v = 0;
        if (nbits != 24) begin
            exp_e = 1;
        end else if (cmd == CH_A) begin
            m_held    = model_recon(code);
            m_pending = 1'b1;
        end else if (cmd == CH_B && m_pending) begin
            m_l       = m_held;
            m_r       = model_recon(code);
            m_pending = 1'b0;
            exp_v     = 1;
        end else begin
            exp_e = 1;
        end
        e0 = e_cnt;
        v0 = v_cnt;
        send_frame(word, nbits, lat, mid_busy);
        check({tag, "_err"},   32'(e_cnt - e0), 32'(exp_e));
        check({tag, "_valid"}, 32'(v_cnt - v0), 32'(exp_v));
        check({tag, "_L"},     o_Sample_L, m_l);
        check({tag, "_R"},     o_Sample_R, m_r);
        check({tag, "_busy_mid"}, 32'(mid_busy), 32'h1);
        check({tag, "_busy_end"}, 32'(o_Busy), 32'h0);
        if (exp_e != 0 || exp_v != 0) check({tag, "_latency"}, 32'(lat), 32'd4);
    endtask

    initial begin
        int          e0, v0;
        logic [31:0] w;
        int          nb, r;

        i_Reset     = 1'b1;
        i_SPI_CS    = 1'b1;
        i_SPI_Clock = 1'b0;
        i_SPI_Data  = 1'b0;
        m_pending   = 1'b0;
        m_held      = '0;
        m_l         = '0;
        m_r         = '0;
        repeat (5) @(negedge i_Clock);
        check("rst_L",     o_Sample_L, 32'h0);
        check("rst_R",     o_Sample_R, 32'h0);
        check("rst_valid", 32'(o_Sample_Valid), 32'h0);
        check("rst_err",   32'(o_Frame_Error), 32'h0);
        check("rst_busy",  32'(o_Busy), 32'h0);
        i_Reset = 1'b0;
        repeat (5) @(negedge i_Clock);

        // B without a held L
        do_frame(32'h0032_FFFF, 24, "b_alone");
        check("b_alone_L0", o_Sample_L, 32'h0);

        // Basic pair
        do_frame(32'h0031_8400, 24, "pair1_a");
        do_frame(32'h0032_8000, 24, "pair1_b");
        check("pair1_Lc", o_Sample_L, 32'h0000_0000);
        check("pair1_Rc", o_Sample_R, 32'hFFFF_F000);

        // Last A wins
        do_frame(32'h0031_0000, 24, "lastA_a1");
        do_frame(32'h0031_FFFC, 24, "lastA_a2");
        do_frame(32'h0032_0000, 24, "lastA_b");
        check("lastA_Rc", o_Sample_R, 32'hFFFD_F000);

        // Short and long frames leave the held L intact
        do_frame(32'h0031_1234, 24, "len_a");
        do_frame(32'h0018_C200, 23, "len_23");
        do_frame(32'h0131_8400, 25, "len_25");
        do_frame(32'h0032_8400, 24, "len_b");
        do_frame(32'h0031_8400, 24, "zero_a");
        do_frame(32'h0032_8400, 24, "zero_b");
        check("zero_Lc", o_Sample_L, 32'h0);
        check("zero_Rc", o_Sample_R, 32'h0);

        // Reset after 12 bits of an A frame, CS held low through the rest
        e0 = e_cnt;
        v0 = v_cnt;
        w  = 32'h0031_4000;
        i_SPI_CS = 1'b0;
        repeat (6) @(negedge i_Clock);
        for (int i = 23; i >= 0; i--) begin
            if (i == 11) begin
                i_Reset = 1'b1;
                repeat (3) @(negedge i_Clock);
                i_Reset = 1'b0;
            end
            i_SPI_Data = w[i];
            repeat (4) @(negedge i_Clock);
            i_SPI_Clock = 1'b1;
            repeat (4) @(negedge i_Clock);
            i_SPI_Clock = 1'b0;
        end
        repeat (4) @(negedge i_Clock);
        i_SPI_CS = 1'b1;
        repeat (14) @(negedge i_Clock);
        m_pending = 1'b0;
        m_l       = '0;
        m_r       = '0;
        check("rstmid_err",   32'(e_cnt - e0), 32'h0);
        check("rstmid_valid", 32'(v_cnt - v0), 32'h0);
        check("rstmid_L",     o_Sample_L, 32'h0);
        check("rstmid_R",     o_Sample_R, 32'h0);
        do_frame(32'h0031_9000, 24, "after_rst_a");
        do_frame(32'h0032_7000, 24, "after_rst_b");

        // Random frames
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      w[23:16] = CH_A;
            else if (r < 8) w[23:16] = CH_B;
            else            w[23:16] = 8'($urandom);
            w[15:0]  = 16'($urandom);
            w[31:24] = 8'($urandom);
            r  = int'($urandom_range(0, 9));
            nb = (r == 0) ? 23 : ((r == 1) ? 25 : 24);
            do_frame(w, nb, "rand");
        end

        // CS stuck low with SCK idle
        e0 = e_cnt;
        i_SPI_CS = 1'b0;
        repeat (2100) @(negedge i_Clock);
        check("tmo_busy", 32'(o_Busy), 32'h1);
`ifdef SPI_RX_TIMEOUT_EN
        check("tmo_err_hold", 32'(e_cnt - e0), 32'h1);
        m_pending = 1'b0;
`else
        check("tmo_err_hold", 32'(e_cnt - e0), 32'h0);
`endif
        i_SPI_CS = 1'b1;
        repeat (14) @(negedge i_Clock);
        check("tmo_busy_end",  32'(o_Busy), 32'h0);
        check("tmo_err_total", 32'(e_cnt - e0), 32'h1);
        do_frame(32'h0031_A000, 24, "post_tmo_a");
        do_frame(32'h0032_5000, 24, "post_tmo_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
